avalon_divw: RTL and testbench
==============================

# avalon_divw

Parametrised Avalon-MM divider peripheral for the Nios II system bus. It contains its own iterative restoring divider of configurable width, sticky completion and error flags, and a maskable interrupt. It replaces the fixed 64-bit divider wrapper in the custom-peripheral set, adding a 32-bit bus, per-byte writes, divide-by-zero and overrun detection, and an optional signed mode.

## Interface
- W, 32: operand/result width, legal 8..32; register bits above W write-ignored, read as 0
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- s_address  in  3  word address
- s_byteenable  in  4  byte lanes for writes
- s_chipselect  in  1  slave select
- s_write  in  1  write strobe (wr = s_write & s_chipselect)
- s_writedata  in  32  write data
- s_readdata  out  32  read data, zero read latency, combinational mux on s_address
- irq  out  1  interrupt, = done & irq_en
- busy  out  1  conduit, high while a division is in progress

## Operation
- Register map:
  - 0 DVND (RW, per-byte)
  - 1 DVSR (RW, per-byte)
  - 2 CTRL (write: bit0 start, bit1 signed; read: bit1 last mode)
  - 3 QUO (RO)
  - 4 RMD (RO)
  - 5 STATUS (RO: bit0 ready, bit1 done, bit2 dbz, bit3 ovr)
  - 6 CLR (write-1-to-clear: bit1 done, bit2 dbz, bit3 ovr; reads 0)
  - 7 IRQ_EN (RW, bit0)
- Start (CTRL write with bit0 = 1) while IDLE: capture DVND, DVSR, mode into working registers. Later DVND/DVSR writes do not affect the running operation.
- FSM states:
  - IDLE: on start, DVSR != 0 -> OP with count = W; DVSR == 0 -> FIX
  - OP: one restoring step per cycle on magnitudes (shift remainder, trial subtract, set quotient bit); count decrements; at count 1 -> FIX
  - FIX: load QUO/RMD (with sign correction), set done -> IDLE
- Signed mode: quotient truncates toward zero; remainder takes the sign of the dividend. MIN / -1 yields QUO = MIN, RMD = 0.
- Divide by zero: QUO = all ones (W bits), RMD = dividend, dbz = 1, done = 1.
- Start while not IDLE: ignored, ovr = 1.
- Same-cycle set and clear of a flag: set wins.
- ready = (state == IDLE). busy = !ready.

## Timing
- Reset values: QUO, RMD, DVND, DVSR, flags, irq_en, mode all 0; state IDLE; irq = 0; busy = 0; s_readdata reflects reset registers.
- Start write sampled on edge E0.
  - Normal: busy from E0; results and done visible after edge E0+W+1, busy low the same cycle. Latency is W+1 cycles.
  - Divide by zero: results and done after edge E0+1.
- irq follows done/irq_en combinationally from registers, so it asserts the cycle after the done edge.
- QUO/RMD hold previous results until FIX.
- Reset mid-operation: immediate return to IDLE; all registers cleared; no done.

## Configuration
- DIV_SIGNED_EN defined: CTRL bit1 selects signed two's-complement division; sign pre/post-correction logic is present.
- Not defined: all divisions are unsigned; CTRL bit1 is write-ignored and reads 0; no sign logic is synthesised.

## Test plan
- W=32, unsigned: DVND = 100, DVSR = 7, start -> busy for 33 cycles, then QUO = 14, RMD = 2, STATUS = 0x3.
- DIV_SIGNED_EN, W=32, signed: -7 / 2 -> QUO = 0xFFFFFFFD, RMD = 0xFFFFFFFF. 0x80000000 / -1 -> QUO = 0x80000000, RMD = 0.
- DVND = 0x1234, DVSR = 0 -> two cycles later QUO = 0xFFFFFFFF, RMD = 0x1234, STATUS = 0x7. Write CLR = 0x6 -> STATUS = 0x1.
- IRQ_EN = 1, start 9 / 3, second start 5 cycles later -> ovr set, result stays QUO = 3, RMD = 0; irq = 1 until CLR bit1 is written, same-cycle new done keeps it set.
- W=8 instance: write 0xFFFF_FF2A with byteenable 0x1 to DVND -> reads 0x2A. 0x2A / 0x05 -> QUO = 8, RMD = 2 after 9 cycles.
- Assert reset at cycle 10 of a W=32 division -> busy = 0, QUO = RMD = 0, STATUS = 0x1, irq = 0.

Source files
------------

// File: rtl/avalon_divw.sv
// rtl/avalon_divw.sv - Avalon-MM iterative restoring divider peripheral
// Optional signed mode is compiled in when DIV_SIGNED_EN is defined.
module avalon_divw #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_chipselect,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq,
  output logic        busy
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_OP, S_FIX} state_t;

  state_t        state_q;
  logic [W-1:0]  dvnd_q, dvsr_q, quo_q, rmd_q;
  logic [W-1:0]  acc_q, div_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q, zero_q;
  logic          done_q, dbz_q, ovr_q, irq_en_q;

  logic          wr, start, clr_wr, sgn_req;
  logic [31:0]   wmask, dvnd_m, dvsr_m;
  logic [W-1:0]  dvnd_d, dvsr_d;
  logic [W-1:0]  dvnd_mag, dvsr_mag, quo_res, rmd_res;
  logic [W:0]    rem_sh, diff;

  assign wr     = s_write & s_chipselect;
  assign start  = wr && (s_address == 3'd2) && s_writedata[0];
  assign clr_wr = wr && (s_address == 3'd6);

  // Byte-lane merge at 32 bits, then truncate so bits above W never stick.
  assign wmask  = {{8{s_byteenable[3]}}, {8{s_byteenable[2]}},
                   {8{s_byteenable[1]}}, {8{s_byteenable[0]}}};
  assign dvnd_m = (32'(dvnd_q) & ~wmask) | (s_writedata & wmask);
  assign dvsr_m = (32'(dvsr_q) & ~wmask) | (s_writedata & wmask);
  assign dvnd_d = dvnd_m[W-1:0];
  assign dvsr_d = dvsr_m[W-1:0];

`ifdef DIV_SIGNED_EN
  logic dvnd_neg, dvsr_neg, negq_q, negr_q;

  assign sgn_req  = s_writedata[1];
  assign dvnd_neg = sgn_req & dvnd_q[W-1];
  assign dvsr_neg = sgn_req & dvsr_q[W-1];
  assign dvnd_mag = dvnd_neg ? -dvnd_q : dvnd_q;
  assign dvsr_mag = dvsr_neg ? -dvsr_q : dvsr_q;
  assign quo_res  = negq_q ? -acc_q : acc_q;
  assign rmd_res  = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (start && state_q == S_IDLE) begin
      negq_q <= dvnd_neg ^ dvsr_neg;
      negr_q <= dvnd_neg;
    end
  end
`else
  assign sgn_req  = 1'b0;
  assign dvnd_mag = dvnd_q;
  assign dvsr_mag = dvsr_q;
  assign quo_res  = acc_q;
  assign rmd_res  = rem_q;
`endif

  assign rem_sh = {rem_q, acc_q[W-1]};
  assign diff   = rem_sh - {1'b0, div_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dvnd_q   <= '0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rmd_q    <= '0;
      acc_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ovr_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr && s_address == 3'd0) dvnd_q <= dvnd_d;
      if (wr && s_address == 3'd1) dvsr_q <= dvsr_d;
      if (wr && s_address == 3'd7) irq_en_q <= s_writedata[0];

      // Set terms are ORed after the clear so a coincident set wins.
      done_q <= (state_q == S_FIX) | (done_q & ~(clr_wr & s_writedata[1]));
      dbz_q  <= (state_q == S_FIX && zero_q) | (dbz_q & ~(clr_wr & s_writedata[2]));
      ovr_q  <= (start && state_q != S_IDLE) | (ovr_q & ~(clr_wr & s_writedata[3]));

      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q <= sgn_req;
            zero_q <= (dvsr_q == '0);
            rem_q  <= '0;
            cnt_q  <= CW'(W);
            if (dvsr_q == '0) begin
              acc_q   <= dvnd_q;
              state_q <= S_FIX;
            end else begin
              acc_q   <= dvnd_mag;
              div_q   <= dvsr_mag;
              state_q <= S_OP;
            end
          end
        end
        S_OP: begin
          rem_q <= diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
          acc_q <= {acc_q[W-2:0], ~diff[W]};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          quo_q   <= zero_q ? '1 : quo_res;
          rmd_q   <= zero_q ? acc_q : rmd_res;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      3'd0: s_readdata = 32'(dvnd_q);
      3'd1: s_readdata = 32'(dvsr_q);
      3'd2: s_readdata = {30'd0, mode_q, 1'b0};
      3'd3: s_readdata = 32'(quo_q);
      3'd4: s_readdata = 32'(rmd_q);
      3'd5: s_readdata = {28'd0, ovr_q, dbz_q, done_q, state_q == S_IDLE};
      3'd7: s_readdata = {31'd0, irq_en_q};
      default: s_readdata = '0;
    endcase
  end

  assign irq  = done_q & irq_en_q;
  assign busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_avalon_divw.sv
// tb/tb_avalon_divw.sv - randomized self-checking bench for avalon_divw (W=32 and W=8)
module tb_avalon_divw;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  s_address = '0;
  logic [3:0]  s_byteenable = '0;
  logic        s_write = 1'b0;
  logic        cs32 = 1'b0, cs8 = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] rd32, rd8;
  logic        irq32, irq8, busy32, busy8;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  avalon_divw #(.W(32)) u_div32 (
    .clk(clk), .reset(reset), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_chipselect(cs32), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(rd32), .irq(irq32), .busy(busy32));

  avalon_divw #(.W(8)) u_div8 (
    .clk(clk), .reset(reset), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_chipselect(cs8), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(rd8), .irq(irq8), .busy(busy8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask_of(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: plain integer division on w-bit values.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input bit sg, output logic [31:0] q, output logic [31:0] r);
    logic [31:0] m, aa, bb;
    longint sa, sb;
    m  = wmask_of(w);
    aa = a & m;
    bb = b & m;
    if (bb == 0) begin
      q = m;
      r = aa;
    end else if (sg) begin
      sa = longint'(aa);
      sb = longint'(bb);
      if (aa[w-1]) sa = sa - (longint'(1) << w);
      if (bb[w-1]) sb = sb - (longint'(1) << w);
      q = 32'(sa / sb) & m;
      r = 32'(sa % sb) & m;
    end else begin
      q = aa / bb;
      r = aa % bb;
    end
  endfunction

  task automatic bus_wr(input bit sel, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    s_address    = a;
    s_writedata  = d;
    s_byteenable = be;
    s_write      = 1'b1;
    cs32         = !sel;
    cs8          = sel;
    @(posedge clk);
    #1;
    s_write = 1'b0;
    cs32    = 1'b0;
    cs8     = 1'b0;
  endtask

  task automatic bus_rd(input bit sel, input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a;
    #1;
    d = sel ? rd8 : rd32;
  endtask

  // Counts sampled busy-high cycles starting with the start edge.
  task automatic wait_idle(input bit sel, output int lat);
    lat = 0;
    while ((sel ? busy8 : busy32) && lat < 200) begin
      lat++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_div(input bit sel, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           output logic [31:0] q_got, output logic [31:0] r_got);
    int w, lat;
    bit sg, dbz;
    logic [31:0] eq, er, v;
    w   = sel ? 8 : 32;
    sg  = sgn && SIGNED_EN;
    dbz = ((b & wmask_of(w)) == 0);
    ref_div(w, a, b, sg, eq, er);
    bus_wr(sel, 3'd6, 32'hE, 4'hF);
    bus_wr(sel, 3'd0, a, 4'hF);
    bus_wr(sel, 3'd1, b, 4'hF);
    bus_wr(sel, 3'd2, {30'd0, sgn, 1'b1}, 4'hF);
    wait_idle(sel, lat);
    chk("latency", lat, dbz ? 1 : w + 1);
    bus_rd(sel, 3'd3, q_got);
    chk("quo", q_got, eq);
    bus_rd(sel, 3'd4, r_got);
    chk("rmd", r_got, er);
    bus_rd(sel, 3'd5, v);
    chk("status", v, dbz ? 32'h7 : 32'h3);
    bus_rd(sel, 3'd2, v);
    chk("ctrl_mode", v, {30'd0, sg, 1'b0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v, q, r, a, b;
    int lat;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, busy32}, 32'd0);
    chk("rst_irq", {31'd0, irq32}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(1'b0, 3'(i), v);
      chk($sformatf("rst_reg%0d", i), v, (i == 5) ? 32'h1 : 32'h0);
    end

    // 100 / 7
    check_div(1'b0, 32'd100, 32'd7, 1'b0, q, r);
    chk("dir_100_7_q", q, 32'd14);
    chk("dir_100_7_r", r, 32'd2);

    if (SIGNED_EN) begin
      check_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
      chk("dir_m7_2_q", q, 32'hFFFF_FFFD);
      chk("dir_m7_2_r", r, 32'hFFFF_FFFF);
      check_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
      chk("dir_min_m1_q", q, 32'h8000_0000);
      chk("dir_min_m1_r", r, 32'h0);
    end

    // Divide by zero, then clear done/dbz
    check_div(1'b0, 32'h1234, 32'd0, 1'b0, q, r);
    chk("dbz_q", q, 32'hFFFF_FFFF);
    chk("dbz_r", r, 32'h1234);
    bus_wr(1'b0, 3'd6, 32'h6, 4'hF);
    bus_rd(1'b0, 3'd5, v);
    chk("dbz_clr_status", v, 32'h1);
    bus_rd(1'b0, 3'd6, v);
    chk("clr_reads0", v, 32'h0);

    // Overrun, irq and set-wins-over-clear
    bus_wr(1'b0, 3'd0, 32'd9, 4'hF);
    bus_wr(1'b0, 3'd1, 32'd3, 4'hF);
    bus_wr(1'b0, 3'd7, 32'd1, 4'hF);
    bus_wr(1'b0, 3'd2, 32'd1, 4'hF);
    repeat (4) @(posedge clk);
    bus_wr(1'b0, 3'd2, 32'd1, 4'hF);
    bus_wr(1'b0, 3'd0, 32'd100, 4'hF);
    wait_idle(1'b0, lat);
    chk("ovr_idle", {31'd0, busy32}, 32'd0);
    bus_rd(1'b0, 3'd3, v);
    chk("ovr_quo", v, 32'd3);
    bus_rd(1'b0, 3'd4, v);
    chk("ovr_rmd", v, 32'd0);
    bus_rd(1'b0, 3'd5, v);
    chk("ovr_status", v, 32'hB);
    chk("ovr_irq", {31'd0, irq32}, 32'd1);
    bus_wr(1'b0, 3'd6, 32'h2, 4'hF);
    chk("irq_cleared", {31'd0, irq32}, 32'd0);
    bus_wr(1'b0, 3'd2, 32'd1, 4'hF);
    repeat (32) @(posedge clk);
    bus_wr(1'b0, 3'd6, 32'h2, 4'hF);
    chk("set_wins_irq", {31'd0, irq32}, 32'd1);
    bus_rd(1'b0, 3'd5, v);
    chk("set_wins_status", v, 32'hB);

    // Byte enables
    bus_wr(1'b0, 3'd0, 32'hAABB_CCDD, 4'hF);
    bus_wr(1'b0, 3'd0, 32'h1122_3344, 4'h5);
    bus_rd(1'b0, 3'd0, v);
    chk("be32_dvnd", v, 32'hAA22_CC44);
    bus_wr(1'b1, 3'd0, 32'hFFFF_FF2A, 4'h1);
    bus_rd(1'b1, 3'd0, v);
    chk("be8_dvnd", v, 32'h2A);
    bus_wr(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF);
    bus_rd(1'b1, 3'd1, v);
    chk("w8_upper_ignored", v, 32'hFF);
    check_div(1'b1, 32'h2A, 32'h05, 1'b0, q, r);
    chk("w8_q", q, 32'd8);
    chk("w8_r", r, 32'd2);

    // Randomized operands on both widths
    for (int i = 0; i < 36; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom & 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      check_div((i % 3) == 2, a, b, 1'($urandom_range(0, 1)), q, r);
    end

    // Reset in the middle of a division
    bus_wr(1'b0, 3'd7, 32'd1, 4'hF);
    bus_wr(1'b0, 3'd0, 32'd123456, 4'hF);
    bus_wr(1'b0, 3'd1, 32'd77, 4'hF);
    bus_wr(1'b0, 3'd2, 32'd1, 4'hF);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #10;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy32}, 32'd0);
    chk("midrst_irq", {31'd0, irq32}, 32'd0);
    bus_rd(1'b0, 3'd3, v);
    chk("midrst_quo", v, 32'd0);
    bus_rd(1'b0, 3'd4, v);
    chk("midrst_rmd", v, 32'd0);
    bus_rd(1'b0, 3'd5, v);
    chk("midrst_status", v, 32'h1);
    bus_rd(1'b0, 3'd7, v);
    chk("midrst_irqen", v, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    bus_rd(1'b0, 3'd5, v);
    chk("midrst_no_done", v, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
